// File: rtl/serial_add_sub.sv
// Bit-serial ripple adder/subtractor: one full-adder slice reused over WIDTH cycles,
// LSB first, with start/busy/done handshake and signed-overflow detection.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_shift;
    logic             carry;
    logic [CW-1:0]    count;
    logic             bit_s, bit_c, last, accept;

    always_comb begin
        bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
        bit_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_shift = sum >> 1;
        sum_shift[WIDTH-1] = bit_s;
        last      = (count == LAST);
        accept    = start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Subtract is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == SHIFT) begin
            sum   <= sum_shift;
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= bit_c;
            count <= count + CW'(1);
            if (last) begin
                cout <= bit_c;
                ovf  <= carry ^ bit_c;
            end
        end
    end

endmodule
